// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS main controller:
//   - opcode constants (IR[31:26])
//   - alu_op, alu_src_b and pc_src select codes
//   - 4-bit FSM state enum (also exported on the debug `state` port)
//   - packed control word produced by the state decoder
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // alu_op codes
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // alu_src_b selects
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // pc_src selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        JUMP   = 4'd12,
        TRAP   = 4'd13
    } state_e;

    // wait_mem marks the states that access memory and may stall; in those
    // states pc_write, ir_write and instr_done are further qualified by ready.
    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       illegal_op;
        logic       wait_mem;
    } ctrl_word_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// ---------------------------------------------------------------------------
// mc_ctrl_decode
// Purely combinational state -> control word decoder (Moore outputs).
// Ports:
//   state_i [3:0]  current FSM state (any encoding, unused ones decode to 0)
//   cw_o           control word, before ready gating
// ---------------------------------------------------------------------------
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    output ctrl_word_t cw_o
);

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        cw_o = '0;
        case (state_i)
            FETCH: begin
                cw_o.mem_read  = 1'b1;
                cw_o.alu_src_b = SRCB_FOUR;
                cw_o.ir_write  = 1'b1;
                cw_o.pc_write  = 1'b1;
                cw_o.wait_mem  = 1'b1;
            end
            DECODE: begin
                cw_o.alu_src_b = SRCB_IMM_SH2;
            end
            MEMADR, ADDIEX: begin
                cw_o.alu_src_a = 1'b1;
                cw_o.alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                cw_o.iord     = 1'b1;
                cw_o.mem_read = 1'b1;
                cw_o.wait_mem = 1'b1;
            end
            MEMWB: begin
                cw_o.mem_to_reg = 1'b1;
                cw_o.reg_write  = 1'b1;
                cw_o.instr_done = 1'b1;
            end
            MEMWR: begin
                cw_o.iord       = 1'b1;
                cw_o.mem_write  = 1'b1;
                cw_o.instr_done = 1'b1;
                cw_o.wait_mem   = 1'b1;
            end
            EXEC: begin
                cw_o.alu_src_a = 1'b1;
                cw_o.alu_op    = ALU_FUNCT;
            end
            ALUWB: begin
                cw_o.reg_dst    = 1'b1;
                cw_o.reg_write  = 1'b1;
                cw_o.instr_done = 1'b1;
            end
            BRANCH: begin
                cw_o.alu_src_a  = 1'b1;
                cw_o.alu_op     = ALU_SUB;
                cw_o.pc_src     = PCSRC_ALUOUT;
                cw_o.branch     = 1'b1;
                cw_o.instr_done = 1'b1;
            end
            ADDIWB: begin
                cw_o.reg_write  = 1'b1;
                cw_o.instr_done = 1'b1;
            end
            JUMP: begin
                cw_o.pc_src     = PCSRC_JUMP;
                cw_o.pc_write   = 1'b1;
                cw_o.instr_done = 1'b1;
            end
            TRAP: begin
                cw_o.illegal_op = 1'b1;
            end
            default: begin
                cw_o = '0;   // IDLE and unused encodings
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
// Main control FSM of the multi-cycle MIPS datapath.
// Parameters:
//   MEM_HANDSHAKE  1: memory states wait for mem_ready; 0: mem_ready ignored
//   EXT_OPS        1: addi / j decoded; 0: they trap as illegal
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   op [5:0]              IR[31:26], sampled in DECODE only
//   mem_ready             memory finishes the current access this cycle
//   pc_write .. alu_src_a single-bit datapath enables/selects
//   alu_src_b, alu_op, pc_src [1:0] mux/ALU selects
//   instr_done            pulse in the last cycle of each instruction
//   illegal_op            pulse in TRAP
//   state [3:0]           current state (debug)
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit EXT_OPS       = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_e     state_q, state_d;
    logic       is_lw_q, is_lw_d;   // memory opcode class latched in DECODE
    logic       ready;
    ctrl_word_t cw;

    assign ready = mem_ready || !MEM_HANDSHAKE;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge value, independent of block order.
            state_q <= IDLE;
            is_lw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_lw_q <= is_lw_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        is_lw_d = is_lw_q;
        case (state_q)
            IDLE:   state_d = FETCH;
            FETCH:  if (ready) state_d = DECODE;
            DECODE: begin
                is_lw_d = (op == OP_LW);
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = EXT_OPS ? ADDIEX : TRAP;
                    OP_J:         state_d = EXT_OPS ? JUMP   : TRAP;
                    default:      state_d = TRAP;
                endcase
            end
            MEMADR: state_d = is_lw_q ? MEMRD : MEMWR;
            MEMRD:  if (ready) state_d = MEMWB;
            MEMWR:  if (ready) state_d = FETCH;
            EXEC:   state_d = ALUWB;
            ADDIEX: state_d = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP, TRAP: state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state_i (state_q),
        .cw_o    (cw)
    );

    // Strobes that commit a memory access are held back until ready; the rest
    // come straight from the state register.
    assign pc_write   = cw.pc_write   && (!cw.wait_mem || ready);
    assign ir_write   = cw.ir_write   && (!cw.wait_mem || ready);
    assign instr_done = cw.instr_done && (!cw.wait_mem || ready);

    assign branch     = cw.branch;
    assign iord       = cw.iord;
    assign mem_read   = cw.mem_read;
    assign mem_write  = cw.mem_write;
    assign reg_dst    = cw.reg_dst;
    assign mem_to_reg = cw.mem_to_reg;
    assign reg_write  = cw.reg_write;
    assign alu_src_a  = cw.alu_src_a;
    assign alu_src_b  = cw.alu_src_b;
    assign alu_op     = cw.alu_op;
    assign pc_src     = cw.pc_src;
    assign illegal_op = cw.illegal_op;
    assign state      = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control FSM for the multi-cycle MIPS datapath, replacing the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, driving the shared-memory, IR, PC, ALU-mux and register-file enables once per state. It adds an optional memory-ready handshake, the `addi`/`j` opcodes, and an illegal-opcode trap.

## Interface
- `MEM_HANDSHAKE`, default 1: 1 = memory states wait for `mem_ready`; 0 = `mem_ready` ignored (treated as 1).
- `EXT_OPS`, default 1: 1 = `addi` (8) and `j` (2) decoded; 0 = both treated as illegal.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 6: IR[31:26]. Sampled only in DECODE.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write`, `branch`, `iord`, `mem_read`, `mem_write`, `ir_write`, `reg_dst`, `mem_to_reg`, `reg_write`, `alu_src_a` out 1 each: datapath enables/selects.
- `alu_src_b` out 2: 00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- `alu_op` out 2: 00 add, 01 sub, 10 use funct.
- `pc_src` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `instr_done` out 1: one-cycle pulse in the last cycle of every instruction.
- `illegal_op` out 1: one-cycle pulse in TRAP.
- `state` out 4: current state, for debug only.

## Operation
- Outputs are decoded from the state register. Any output not listed for a state is 0.
- IDLE: all outputs 0. Always goes to FETCH next. This is the reset state.
- FETCH: `mem_read`=1, `alu_src_b`=01. `ir_write` and `pc_write` are both equal to `ready`, where `ready` = `mem_ready` | !MEM_HANDSHAKE. Goes to DECODE on `ready`, otherwise holds.
- DECODE: `alu_src_b`=11. Next state by `op`:
  - 35 or 43 -> MEMADR
  - 0 -> EXEC
  - 4 -> BRANCH
  - 8 -> ADDIEX (EXT_OPS only)
  - 2 -> JUMP (EXT_OPS only)
  - anything else -> TRAP
- MEMADR: `alu_src_a`=1, `alu_src_b`=10. Goes to MEMRD if `op` was 35, MEMWR if 43. The opcode class is latched in DECODE into an internal 1-bit register.
- MEMRD: `iord`=1, `mem_read`=1. Goes to MEMWB on `ready`, otherwise holds.
- MEMWB: `mem_to_reg`=1, `reg_write`=1, `instr_done`=1. Goes to FETCH.
- MEMWR: `iord`=1, `mem_write`=1. Goes to FETCH on `ready` with `instr_done`=`ready`, otherwise holds.
- EXEC: `alu_src_a`=1, `alu_op`=10. Goes to ALUWB.
- ALUWB: `reg_dst`=1, `reg_write`=1, `instr_done`=1. Goes to FETCH.
- BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_src`=01, `branch`=1, `instr_done`=1. Goes to FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10. Goes to ADDIWB.
- ADDIWB: `reg_write`=1, `instr_done`=1. Goes to FETCH.
- JUMP: `pc_src`=10, `pc_write`=1, `instr_done`=1. Goes to FETCH.
- TRAP: `illegal_op`=1. Goes to FETCH. The PC has already advanced, so the illegal instruction is skipped. `instr_done` stays 0.
- While a memory state holds waiting for `ready`, its strobes stay asserted and constant.
- Unreachable state encodings go to IDLE next cycle, with all outputs 0.

## Timing
- Reset: asynchronous entry to IDLE, so all outputs are 0 and `state`=IDLE while `rst_n`=0. The first FETCH is the 2nd rising edge after deassertion.
- Cycles per instruction with zero wait, excluding IDLE:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 3
- Each wait cycle adds exactly 1 cycle in FETCH, MEMRD or MEMWR.
- `mem_ready` is combinational into `pc_write`, `ir_write` and `instr_done` only. All other outputs depend only on the state register.
- Reset asserted mid-instruction aborts it immediately. No partial `reg_write` or `mem_write` occurs after assertion.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode constants: OP_RTYPE=0, OP_LW=35, OP_SW=43, OP_BEQ=4, OP_ADDI=8, OP_J=2
  - the `alu_op` codes
  - the `alu_src_b` and `pc_src` select codes
  - the 4-bit state enum: IDLE=0, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP
- Sub-module `mc_ctrl_decode` is purely combinational: state -> control word. The top holds the state register, next-state logic and `ready` gating.

## Test plan
- Reset, then `op`=35 with `mem_ready`=1 held -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. `reg_write`=1 and `mem_to_reg`=1 in cycle 5. `instr_done` pulses once.
- `op`=43 with `mem_ready`=0 for 3 cycles in MEMWR -> `mem_write`=1 for 4 cycles. `instr_done` only on the `ready` cycle. `reg_write` never asserted.
- `op`=0, then `op`=4 -> ALUWB has `reg_dst`=1, `alu_op`=10 in EXEC. BRANCH has `alu_op`=01, `branch`=1, `pc_src`=01. beq totals 3 cycles.
- EXT_OPS=1: `op`=8 gives 4 cycles with `alu_src_b`=10 then `reg_write`=1, `reg_dst`=0. `op`=2 gives `pc_src`=10, `pc_write`=1. EXT_OPS=0: same opcodes -> TRAP with `illegal_op` pulse.
- `op`=63 -> TRAP for 1 cycle, then FETCH. No `reg_write`, `mem_write` or `instr_done`.
- `rst_n` dropped asynchronously mid-MEMRD -> all outputs 0 before the next edge. Then IDLE -> FETCH. MEM_HANDSHAKE=0 with `mem_ready`=0 -> no stalls.
